alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequential front-end that owns the other side of the 32-bit ALU port. It accepts operation requests over a valid/ready handshake and drives operandA, operandB and command into the ALU. It holds those inputs stable for a programmable settle window so the gate-delay ripple chain can resolve, then captures result and flags into a response register. It presents the response over a second valid/ready handshake and keeps sticky overflow and an operation counter for the CPU datapath and test harnesses.

Parameters:
SETTLE_CYCLES, 8, clock cycles the ALU inputs are held before capture; legal range 1..255.
COUNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_command  input  3  ALU opcode (0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR).
req_operandA  input  32  operand A.
req_operandB  input  32  operand B.
alu_operandA  output  32  registered drive to the ALU operandA.
alu_operandB  output  32  registered drive to the ALU operandB.
alu_command  output  3  registered drive to the ALU command.
alu_result  input  32  ALU result.
alu_carryout  input  1  ALU carryout.
alu_zero  input  1  ALU zero.
alu_overflow  input  1  ALU overflow.
rsp_valid  output  1  response held and valid.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  32  captured result.
rsp_carryout  output  1  captured carryout.
rsp_zero  output  1  captured zero.
rsp_overflow  output  1  captured overflow.
clear_sticky  input  1  clears sticky_overflow.
sticky_overflow  output  1  set by any captured overflow.
op_count  output  COUNT_WIDTH  completed responses, modulo 2^COUNT_WIDTH.

Behaviour:
- Reset values (reset=1 at any edge, in any state):
  - state IDLE; req_ready=1; rsp_valid=0.
  - alu_operandA, alu_operandB, alu_command, rsp_* all 0.
  - sticky_overflow=0; op_count=0; settle counter=0.
  - An in-flight operation is abandoned and produces no response.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge: latch req_operandA, req_operandB, req_command into the alu_* registers; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - req_ready=0; alu_* outputs are held constant.
  - Counter decrements each edge.
  - At the edge where the counter is 0: capture alu_result and all three flags into rsp_*; set rsp_valid=1; go to HOLD.
- Latency: request accepted at edge k gives rsp_valid=1 after edge k+SETTLE_CYCLES. With SETTLE_CYCLES=1, capture occurs at edge k+1.
- HOLD:
  - req_ready=0; rsp_* and alu_* held stable.
  - When rsp_ready=1 at an edge: rsp_valid goes to 0, op_count increments, go to IDLE.
  - rsp_* keep their last values after the handshake until the next capture.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. No request is accepted in the same cycle as a response handshake.
- req_valid outside IDLE is ignored; the request is not queued. Requester inputs may change freely while req_ready=0.
- Sticky overflow: set at a capture edge with alu_overflow=1. Cleared at an edge with clear_sticky=1. If both occur at the same edge, set wins (result 1).
- op_count wraps from all-ones to 0 with no flag.
- Flags are captured verbatim; no reinterpretation. The ALU reports carry/overflow only for ADD/SUB, so those flags are 0 for other opcodes.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- ADD 5+3, SETTLE_CYCLES=8, rsp_ready=1 → rsp_valid rises exactly 8 edges after accept; result 0x00000008, carry 0, zero 0, overflow 0; op_count=1.
- SUB 0x80000000−1 → result 0x7FFFFFFF, overflow 1, sticky_overflow 1. Then SUB 5−5 → result 0, zero 1, carry 1, sticky still 1. Then clear_sticky pulse → sticky 0.
- SLT 0xFFFFFFFF vs 0x00000001 → result 0x00000001. Then AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000, carry 0, overflow 0.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid with a second req_valid asserted → rsp_* stable, req_ready 0, second request not accepted until one cycle after the rsp handshake.
- Assert reset during SETTLE (3rd cycle) → next cycle state IDLE, alu_* = 0, rsp_valid 0, op_count unchanged from 0; no response ever appears.
- Preload 2^COUNT_WIDTH−1 completions → next response sets op_count=0. Set and clear_sticky at the same capture edge → sticky_overflow=1.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals shared by the sequencer and its environment.
// master = the sequencer itself; slave = requester, ALU and consumer side.
interface alu_op_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_command;
   logic [31:0] req_operandA;
   logic [31:0] req_operandB;
   logic [31:0] alu_operandA;
   logic [31:0] alu_operandB;
   logic [2:0]  alu_command;
   logic [31:0] alu_result;
   logic        alu_carryout;
   logic        alu_zero;
   logic        alu_overflow;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_carryout;
   logic        rsp_zero;
   logic        rsp_overflow;

   modport master (
      input  req_valid, req_command, req_operandA, req_operandB,
      input  alu_result, alu_carryout, alu_zero, alu_overflow,
      input  rsp_ready,
      output req_ready, alu_operandA, alu_operandB, alu_command,
      output rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
   );

   modport slave (
      output req_valid, req_command, req_operandA, req_operandB,
      output alu_result, alu_carryout, alu_zero, alu_overflow,
      output rsp_ready,
      input  req_ready, alu_operandA, alu_operandB, alu_command,
      input  rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end for the ripple ALU: latches a request, holds ALU inputs for a settle
// window, captures result/flags and presents them until the consumer accepts.
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 8,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   alu_op_sequencer_if.master     bus,
   input  logic                   clear_sticky,
   output logic                   sticky_overflow,
   output logic [COUNT_WIDTH-1:0] op_count
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_next;
   logic [7:0]             r_cnt;
   logic [31:0]            r_alu_a;
   logic [31:0]            r_alu_b;
   logic [2:0]             r_alu_cmd;
   logic                   r_rsp_valid;
   logic [31:0]            r_rsp_result;
   logic                   r_rsp_carry;
   logic                   r_rsp_zero;
   logic                   r_rsp_ovf;
   logic                   r_sticky;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_accept;
   logic                   w_capture;
   logic                   w_release;
   logic                   w_req_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.req_valid)  w_next = S_SETTLE;
         S_SETTLE: if (r_cnt == 8'd0)  w_next = S_HOLD;
         S_HOLD:   if (bus.rsp_ready)  w_next = S_IDLE;
         default:                      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = (r_state == S_IDLE);
      w_accept    = (r_state == S_IDLE)   && bus.req_valid;
      w_capture   = (r_state == S_SETTLE) && (r_cnt == 8'd0);
      w_release   = (r_state == S_HOLD)   && bus.rsp_ready;
   end

   // Accept: ALU drive is latched once and stays frozen through SETTLE and HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_a   <= 32'd0;
         r_alu_b   <= 32'd0;
         r_alu_cmd <= 3'd0;
         r_cnt     <= 8'd0;
      end else begin
         if (w_accept) begin
            r_alu_a   <= bus.req_operandA;
            r_alu_b   <= bus.req_operandB;
            r_alu_cmd <= bus.req_command;
            r_cnt     <= CNT_LOAD;
         end else if (r_state == S_SETTLE && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
         end
      end
   end

   // Capture: rsp_* keep their values after the handshake until the next capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= 32'd0;
         r_rsp_carry  <= 1'b0;
         r_rsp_zero   <= 1'b0;
         r_rsp_ovf    <= 1'b0;
      end else begin
         if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= bus.alu_result;
            r_rsp_carry  <= bus.alu_carryout;
            r_rsp_zero   <= bus.alu_zero;
            r_rsp_ovf    <= bus.alu_overflow;
         end else if (w_release) begin
            r_rsp_valid  <= 1'b0;
         end
      end
   end

   // A captured overflow outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sticky <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_capture && bus.alu_overflow) r_sticky <= 1'b1;
         else if (clear_sticky)             r_sticky <= 1'b0;
         if (w_release) r_count <= r_count + 1'b1;
      end
   end

   assign bus.req_ready    = w_req_ready;
   assign bus.alu_operandA = r_alu_a;
   assign bus.alu_operandB = r_alu_b;
   assign bus.alu_command  = r_alu_cmd;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_result   = r_rsp_result;
   assign bus.rsp_carryout = r_rsp_carry;
   assign bus.rsp_zero     = r_rsp_zero;
   assign bus.rsp_overflow = r_rsp_ovf;
   assign sticky_overflow  = r_sticky;
   assign op_count         = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU on the far side.
module tb_alu_op_sequencer;
   localparam int SETTLE = 8;
   localparam int CW     = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear_sticky = 1'b0;
   logic          sticky_overflow;
   logic [CW-1:0] op_count;
   logic [32:0]   m_sum;
   int            n_chk = 0;
   int            n_err = 0;
   int            lat;
   logic          saw;

   alu_op_sequencer_if bus();

   alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .COUNT_WIDTH(CW)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .clear_sticky    (clear_sticky),
      .sticky_overflow (sticky_overflow),
      .op_count        (op_count)
   );

   always #5 clk = ~clk;

   // ALU model: carry/overflow only meaningful for ADD and SUB.
   always_comb begin
      m_sum            = 33'd0;
      bus.alu_result   = 32'd0;
      bus.alu_carryout = 1'b0;
      bus.alu_overflow = 1'b0;
      case (bus.alu_command)
         3'd0: begin
            m_sum            = {1'b0, bus.alu_operandA} + {1'b0, bus.alu_operandB};
            bus.alu_result   = m_sum[31:0];
            bus.alu_carryout = m_sum[32];
            bus.alu_overflow = (bus.alu_operandA[31] == bus.alu_operandB[31]) &&
                               (m_sum[31] != bus.alu_operandA[31]);
         end
         3'd1: begin
            m_sum            = {1'b0, bus.alu_operandA} + {1'b0, ~bus.alu_operandB} + 33'd1;
            bus.alu_result   = m_sum[31:0];
            bus.alu_carryout = m_sum[32];
            bus.alu_overflow = (bus.alu_operandA[31] != bus.alu_operandB[31]) &&
                               (m_sum[31] != bus.alu_operandA[31]);
         end
         3'd2: bus.alu_result = bus.alu_operandA ^ bus.alu_operandB;
         3'd3: bus.alu_result = {31'd0, ($signed(bus.alu_operandA) < $signed(bus.alu_operandB))};
         3'd4: bus.alu_result = bus.alu_operandA & bus.alu_operandB;
         3'd5: bus.alu_result = ~(bus.alu_operandA & bus.alu_operandB);
         3'd6: bus.alu_result = ~(bus.alu_operandA | bus.alu_operandB);
         default: bus.alu_result = bus.alu_operandA | bus.alu_operandB;
      endcase
      bus.alu_zero = (bus.alu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (!bus.req_ready && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk("req_ready_timeout", 32'd0, 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_command  = cmd;
      bus.req_operandA = a;
      bus.req_operandB = b;
      step();
      bus.req_valid    = 1'b0;
   endtask

   task automatic wait_rsp(output int l);
      l = 0;
      while (!bus.rsp_valid && l < 40) begin
         step();
         l++;
      end
      if (l >= 40) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_command  = 3'd0;
      bus.req_operandA = 32'd0;
      bus.req_operandB = 32'd0;
      bus.rsp_ready    = 1'b0;
      step();
      step();
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_alu_a", bus.alu_operandA, 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_sticky", {31'd0, sticky_overflow}, 32'd0);
      chk("rst_count", {29'd0, op_count}, 32'd0);
      reset = 1'b0;

      // reset in the middle of SETTLE abandons the operation
      issue(3'd0, 32'd1, 32'd2);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("abort_alu_a", bus.alu_operandA, 32'd0);
      chk("abort_alu_b", bus.alu_operandB, 32'd0);
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_count", {29'd0, op_count}, 32'd0);
      saw = 1'b0;
      repeat (15) begin
         step();
         if (bus.rsp_valid) saw = 1'b1;
      end
      chk("abort_no_rsp", {31'd0, saw}, 32'd0);

      // ADD 5+3
      issue(3'd0, 32'd5, 32'd3);
      chk("add_alu_a_held", bus.alu_operandA, 32'd5);
      wait_rsp(lat);
      chk("add_latency", 32'(lat), 32'(SETTLE));
      chk("add_result", bus.rsp_result, 32'h8);
      chk("add_carry", {31'd0, bus.rsp_carryout}, 32'd0);
      chk("add_zero", {31'd0, bus.rsp_zero}, 32'd0);
      chk("add_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
      release_rsp();
      chk("add_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
      chk("add_count", {29'd0, op_count}, 32'd1);
      chk("add_result_kept", bus.rsp_result, 32'h8);

      // SUB with signed overflow
      issue(3'd1, 32'h8000_0000, 32'd1);
      wait_rsp(lat);
      chk("subovf_result", bus.rsp_result, 32'h7FFF_FFFF);
      chk("subovf_ovf", {31'd0, bus.rsp_overflow}, 32'd1);
      chk("subovf_carry", {31'd0, bus.rsp_carryout}, 32'd1);
      chk("subovf_sticky", {31'd0, sticky_overflow}, 32'd1);
      release_rsp();

      // SUB 5-5
      issue(3'd1, 32'd5, 32'd5);
      wait_rsp(lat);
      chk("subz_result", bus.rsp_result, 32'd0);
      chk("subz_zero", {31'd0, bus.rsp_zero}, 32'd1);
      chk("subz_carry", {31'd0, bus.rsp_carryout}, 32'd1);
      chk("subz_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
      chk("subz_sticky", {31'd0, sticky_overflow}, 32'd1);
      release_rsp();
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      chk("clear_sticky", {31'd0, sticky_overflow}, 32'd0);

      // SLT and AND
      issue(3'd3, 32'hFFFF_FFFF, 32'd1);
      wait_rsp(lat);
      chk("slt_result", bus.rsp_result, 32'd1);
      release_rsp();
      issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_rsp(lat);
      chk("and_result", bus.rsp_result, 32'hF000_F000);
      chk("and_carry", {31'd0, bus.rsp_carryout}, 32'd0);
      chk("and_ovf", {31'd0, bus.rsp_overflow}, 32'd0);
      release_rsp();
      chk("count_5", {29'd0, op_count}, 32'd5);

      // back-pressure with a competing request waiting
      issue(3'd7, 32'h0000_000F, 32'h0000_00F0);
      wait_rsp(lat);
      bus.req_valid    = 1'b1;
      bus.req_command  = 3'd2;
      bus.req_operandA = 32'h0000_1234;
      bus.req_operandB = 32'h0000_00FF;
      repeat (5) begin
         step();
         chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("bp_rsp_result", bus.rsp_result, 32'h0000_00FF);
         chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
         chk("bp_alu_a", bus.alu_operandA, 32'h0000_000F);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("bp_hs_alu_a", bus.alu_operandA, 32'h0000_000F);
      chk("bp_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("bp_hs_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("bp_hs_count", {29'd0, op_count}, 32'd6);
      step();
      bus.req_valid = 1'b0;
      chk("bp_accept_alu_a", bus.alu_operandA, 32'h0000_1234);
      chk("bp_accept_req_ready", {31'd0, bus.req_ready}, 32'd0);
      wait_rsp(lat);
      chk("bp2_latency", 32'(lat), 32'(SETTLE));
      chk("bp2_result", bus.rsp_result, 32'h0000_12CB);
      release_rsp();
      chk("count_all_ones", {29'd0, op_count}, 32'd7);
      chk("sticky_still_clear", {31'd0, sticky_overflow}, 32'd0);

      // overflow capture and clear_sticky on the same edge; counter wraps
      issue(3'd1, 32'h8000_0000, 32'd1);
      repeat (SETTLE - 1) step();
      chk("pre_capture_valid", {31'd0, bus.rsp_valid}, 32'd0);
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      chk("same_edge_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("same_edge_sticky", {31'd0, sticky_overflow}, 32'd1);
      release_rsp();
      chk("count_wrap", {29'd0, op_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
